// File: rtl/core_seq.sv
// Multi-cycle RV64 OP/OP-IMM integer core: fetch from a 1-cycle synchronous imem,
// execute on alu, write back. Halts on ebreak or any unsupported instruction.

module alu #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    output logic [XLEN-1:0] y_o
);
    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    logic          alt;
    logic          unused_f7;

    assign shamt     = b_i[SW-1:0];
    assign alt       = funct7_i[5];
    assign unused_f7 = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        y_o = '0;
        case (funct3_i)
            3'b000: y_o = alt ? (a_i - b_i) : (a_i + b_i);
            3'b001: y_o = a_i << shamt;
            3'b010: y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            3'b011: y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            3'b100: y_o = a_i ^ b_i;
            3'b101: y_o = alt ? $unsigned($signed(a_i) >>> shamt) : (a_i >> shamt);
            3'b110: y_o = a_i | b_i;
            3'b111: y_o = a_i & b_i;
            default: y_o = '0;
        endcase
    end
endmodule

// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | imem_addr = pc, instruction word arrives next cycle
// EXEC   | decode, execute, write back (or halt)
// HALTED | stopped after ebreak/illegal, waiting for start
module core_seq #(
    parameter int XLEN     = 64,
    parameter int IMEM_AW  = 15,
    parameter int START_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [31:0]        retired,
    input  logic [4:0]         dbg_addr,
    output logic [XLEN-1:0]    dbg_data
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

    localparam logic [IMEM_AW-1:0] START_W = IMEM_AW'(START_PC);
    localparam logic [31:0]        EBREAK  = 32'h0010_0073;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [31:0]        retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic [XLEN-1:0]    rf_q [32];

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic            is_op, is_opi;
    logic [XLEN-1:0] rs1_val, rs2_val, imm, alu_b, alu_y;
    logic [6:0]      alu_f7;
    logic            wr_en;

    assign opcode  = imem_data[6:0];
    assign rd      = imem_data[11:7];
    assign funct3  = imem_data[14:12];
    assign rs1     = imem_data[19:15];
    assign rs2     = imem_data[24:20];
    assign is_op   = (opcode == 7'b0110011);
    assign is_opi  = (opcode == 7'b0010011);
    assign rs1_val = rf_q[rs1];
    assign rs2_val = rf_q[rs2];
    assign imm     = {{(XLEN-12){imem_data[31]}}, imem_data[31:20]};
    assign alu_b   = is_op ? rs2_val : imm;

    // Only shift-right immediates may select the arithmetic variant; ADDI never subtracts.
    always_comb begin
        alu_f7 = 7'b0;
        if (is_op)
            alu_f7 = imem_data[31:25];
        else if (funct3 == 3'b101)
            alu_f7 = {1'b0, imem_data[30], 5'b0};
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a_i      (rs1_val),
        .b_i      (alu_b),
        .funct3_i (funct3),
        .funct7_i (alu_f7),
        .y_o      (alu_y)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        wr_en     = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = START_W;
                    retired_d = '0;
                    illegal_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (is_op || is_opi) begin
                    wr_en     = 1'b1;
                    pc_d      = pc_q + 1'b1;
                    retired_d = (retired_q == '1) ? retired_q : retired_q + 32'd1;
                    state_d   = S_FETCH;
                end else begin
                    illegal_d = (imem_data != EBREAK);
                    state_d   = S_HALTED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= START_W;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wr_en && (rd != 5'd0)) begin
            rf_q[rd] <= alu_y;
        end
    end

    assign imem_addr = pc_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted    = (state_q == S_HALTED);
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign dbg_data  = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];
endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: small programs in a modelled synchronous imem,
// results checked through the debug read port and status outputs.

module tb_core_seq;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2;
    logic [14:0] imem_addr;
    logic [31:0] imem_data;
    logic        busy, halted, illegal;
    logic [31:0] retired;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;

    logic [1:0]  imem_addr2;
    logic [31:0] imem_data2;
    logic        busy2, halted2, illegal2;
    logic [31:0] retired2;
    logic [4:0]  dbg_addr2;
    logic [63:0] dbg_data2;

    logic [31:0] mem  [0:32767];
    logic [31:0] mem2 [0:3];

    int total = 0;
    int bad   = 0;

    core_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .halted(halted), .illegal(illegal), .retired(retired),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    core_seq #(.XLEN(64), .IMEM_AW(2), .START_PC(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .busy(busy2), .halted(halted2), .illegal(illegal2), .retired(retired2),
        .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    always @(posedge clk) imem_data  <= mem[imem_addr];
    always @(posedge clk) imem_data2 <= mem2[imem_addr2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [63:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic load_base();
        mem[0] = 32'h0050_0093;  // addi x1,x0,5
        mem[1] = 32'hFFD0_0113;  // addi x2,x0,-3
        mem[2] = 32'h0020_81B3;  // add  x3,x1,x2
        mem[3] = 32'h4020_8233;  // sub  x4,x1,x2
        mem[4] = 32'h0010_0073;  // ebreak
    endtask

    task automatic test_reset();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; dbg_addr = 5'd0; dbg_addr2 = 5'd1;
        tick(); tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %0b want 0", illegal); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
        total++; if (imem_addr !== 15'd0) begin bad++; $display("FAIL reset_imem_addr: got %0d want 0", imem_addr); end
        read_reg(5'd1, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL reset_x1: got %0h want 0", v); end
    endtask

    task automatic test_program();
        int cyc;
        logic [63:0] v;
        load_base();
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL prog_busy: got %0b want 1", busy); end
        run_to_halt(cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL prog_halt_latency: got %0d want 10", cyc); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL prog_illegal: got %0b want 0", illegal); end
        total++; if (retired !== 32'd4) begin bad++; $display("FAIL prog_retired: got %0d want 4", retired); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prog_busy_halted: got %0b want 0", busy); end
        read_reg(5'd1, v);
        total++; if (v !== 64'd5) begin bad++; $display("FAIL prog_x1: got %0h want 5", v); end
        read_reg(5'd2, v);
        total++; if (v !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL prog_x2: got %0h want fffffffffffffffd", v); end
        read_reg(5'd3, v);
        total++; if (v !== 64'd2) begin bad++; $display("FAIL prog_x3: got %0h want 2", v); end
        read_reg(5'd4, v);
        total++; if (v !== 64'd8) begin bad++; $display("FAIL prog_x4: got %0h want 8", v); end
    endtask

    task automatic test_alu_ops();
        int cyc;
        logic [63:0] v;
        mem[0] = 32'h0011_2433;  // slt  x8,x2,x1
        mem[1] = 32'h0011_34B3;  // sltu x9,x2,x1
        mem[2] = 32'h0020_C533;  // xor  x10,x1,x2
        mem[3] = 32'h0020_F5B3;  // and  x11,x1,x2
        mem[4] = 32'h0021_6613;  // ori  x12,x2,2
        mem[5] = 32'h0010_0073;  // ebreak
        pulse_start();
        run_to_halt(cyc);
        total++; if (cyc != 12) begin bad++; $display("FAIL alu_halt_latency: got %0d want 12", cyc); end
        total++; if (retired !== 32'd5) begin bad++; $display("FAIL alu_retired: got %0d want 5", retired); end
        read_reg(5'd8, v);
        total++; if (v !== 64'd1) begin bad++; $display("FAIL alu_slt: got %0h want 1", v); end
        read_reg(5'd9, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL alu_sltu: got %0h want 0", v); end
        read_reg(5'd10, v);
        total++; if (v !== 64'hFFFF_FFFF_FFFF_FFF8) begin bad++; $display("FAIL alu_xor: got %0h want fffffffffffffff8", v); end
        read_reg(5'd11, v);
        total++; if (v !== 64'd5) begin bad++; $display("FAIL alu_and: got %0h want 5", v); end
        read_reg(5'd12, v);
        total++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL alu_ori: got %0h want ffffffffffffffff", v); end
    endtask

    task automatic test_shifts();
        int cyc;
        logic [63:0] v;
        mem[0] = 32'h4011_5293;  // srai x5,x2,1
        mem[1] = 32'h03C1_5313;  // srli x6,x2,60
        mem[2] = 32'h03F0_9393;  // slli x7,x1,63
        mem[3] = 32'h0010_0073;  // ebreak
        pulse_start();
        run_to_halt(cyc);
        total++; if (retired !== 32'd3) begin bad++; $display("FAIL shift_retired: got %0d want 3", retired); end
        read_reg(5'd5, v);
        total++; if (v !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL shift_srai: got %0h want fffffffffffffffe", v); end
        read_reg(5'd6, v);
        total++; if (v !== 64'hF) begin bad++; $display("FAIL shift_srli: got %0h want f", v); end
        read_reg(5'd7, v);
        total++; if (v !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL shift_slli: got %0h want 8000000000000000", v); end
    endtask

    task automatic test_x0_illegal();
        int cyc;
        logic [63:0] v;
        mem[0] = 32'h0070_0013;  // addi x0,x0,7
        mem[1] = 32'hFFFF_FFFF;
        pulse_start();
        tick(); tick();
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL x0_retired_inc: got %0d want 1", retired); end
        read_reg(5'd0, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL x0_value: got %0h want 0", v); end
        run_to_halt(cyc);
        total++; if (cyc != 2) begin bad++; $display("FAIL ill_halt_latency: got %0d want 2", cyc); end
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_flag: got %0b want 1", illegal); end
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL ill_retired: got %0d want 1", retired); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        load_base();
        pulse_start();
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL restart_clears_illegal: got %0b want 0", illegal); end
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_halt(cyc);
        total++; if (cyc != 6) begin bad++; $display("FAIL busy_start_latency: got %0d want 6", cyc); end
        total++; if (retired !== 32'd4) begin bad++; $display("FAIL busy_start_retired: got %0d want 4", retired); end
        pulse_start();
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL rerun_retired_clr: got %0d want 0", retired); end
        total++; if (imem_addr !== 15'd0) begin bad++; $display("FAIL rerun_pc: got %0d want 0", imem_addr); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rerun_halted: got %0b want 0", halted); end
        run_to_halt(cyc);
        total++; if (cyc != 10) begin bad++; $display("FAIL rerun_latency: got %0d want 10", cyc); end
        total++; if (retired !== 32'd4) begin bad++; $display("FAIL rerun_retired: got %0d want 4", retired); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] v;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_base();
        pulse_start();
        tick(); tick(); tick(); tick(); tick();
        total++; if (retired !== 32'd2) begin bad++; $display("FAIL mid_retired_before: got %0d want 2", retired); end
        total++; if (imem_addr !== 15'd2) begin bad++; $display("FAIL mid_pc_before: got %0d want 2", imem_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL mid_retired: got %0d want 0", retired); end
        total++; if (imem_addr !== 15'd0) begin bad++; $display("FAIL mid_pc: got %0d want 0", imem_addr); end
        read_reg(5'd3, v);
        total++; if (v !== 64'd0) begin bad++; $display("FAIL mid_x3: got %0h want 0", v); end
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_stays_idle: got %0b want 0", busy); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) mem2[i] = 32'h0010_8093;  // addi x1,x1,1
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (imem_addr2 !== 2'(i % 4)) begin
                bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, imem_addr2, i % 4);
            end
            total++;
            if (dbg_data2 !== 64'(i)) begin
                bad++; $display("FAIL wrap_x1[%0d]: got %0h want %0h", i, dbg_data2, i);
            end
            tick(); tick();
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_alu_ops();
        test_shifts();
        test_x0_illegal();
        test_start_ignored();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Parametrised multi-cycle integer core built around the team's existing alu module.
- Fetches 32-bit instructions from an external synchronous-read instruction memory with 1-cycle latency.
- Decodes RV64 OP (R-type) and OP-IMM (I-type), reads a register file, executes on alu, writes back.
- Runs until ebreak or an illegal opcode. Exposes a debug register read port and a retired-instruction counter.

Parameters:
- XLEN, 64, datapath and register width (32 or 64).
- IMEM_AW, 15, instruction memory word-address width.
- START_PC, 0, word address loaded into pc on reset and on start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins execution from START_PC.
- imem_addr  out  IMEM_AW  word address to the instruction memory.
- imem_data  in  32  instruction word, valid one cycle after imem_addr.
- busy  out  1  high while executing.
- halted  out  1  high after ebreak or illegal instruction, until next start/rst.
- illegal  out  1  high if the halt was caused by an unsupported instruction.
- retired  out  32  count of instructions written back since last start.
- dbg_addr  in  5  register index for debug read.
- dbg_data  out  XLEN  combinational read of regfile[dbg_addr]; 0 for index 0.

Behaviour:
- Reset values:
  - FSM in IDLE; pc=START_PC; imem_addr=START_PC.
  - busy=0, halted=0, illegal=0, retired=0.
  - All 32 registers cleared to 0.
- Reset mid-instruction aborts with no writeback.
- FSM states:
  - IDLE: start -> FETCH. Also clears retired/halted/illegal and sets pc=START_PC. Registers are kept.
  - FETCH: imem_addr=pc. Next state EXEC.
  - EXEC: instr = imem_data. Decode, read rs1/rs2, drive alu, then one of:
    - Writeback and retire -> FETCH.
    - Halt -> HALTED.
  - HALTED: busy=0, halted=1. start -> behaves as start from IDLE.
- busy=1 in FETCH and EXEC. start is ignored while busy.
- Throughput: 2 cycles per instruction. Register write, pc+1 and retired+1 all occur on the clock edge ending EXEC.
- pc is a word index. It wraps from 2^IMEM_AW-1 to 0.
- Decode on opcode instr[6:0]:
  - 0110011 (OP): in2 = rs2 value; alu funct3 = instr[14:12]; funct7 = instr[31:25].
  - 0010011 (OP-IMM): in2 = sign-extend(instr[31:20]) to XLEN; funct3 = instr[14:12].
    - funct7 = {1'b0, instr[30], 5'b0} when funct3 = 101.
    - funct7 = 0 for all other funct3, so ADDI never subtracts.
    - Shift amount is in2[log2(XLEN)-1:0].
  - Exactly 0x00100073 (ebreak): no writeback, not counted -> HALTED, illegal=0.
  - Anything else: no writeback, not counted -> HALTED, illegal=1.
- alu semantics by funct3:
  - 000: ADD, or SUB when funct7[5]=1 (OP only).
  - 001: SLL. 010: SLT (signed). 011: SLTU.
  - 100: XOR. 101: SRL, or SRA when funct7[5]=1.
  - 110: OR. 111: AND.
  - Arithmetic wraps modulo 2^XLEN.
- Register file:
  - x0 reads 0; writes to rd=0 are discarded but still counted as retired.
  - Reads are combinational. rs1=rs2=rd is legal: sources are read before the write edge.
- dbg_data reflects a write on the cycle after the write edge.
- retired saturates at 0xFFFFFFFF.

Test Plan:
- Program from word 0:
  - 0x00500093 (addi x1,x0,5)
  - 0xFFD00113 (addi x2,x0,-3)
  - 0x002081B3 (add x3,x1,x2)
  - 0x40208233 (sub x4,x1,x2)
  - 0x00100073 (ebreak)
  - Pulse start -> halted=1 exactly 10 cycles after start. illegal=0, retired=4.
  - dbg reads: x1=5, x2=0xFFFFFFFFFFFFFFFD, x3=2, x4=8.
- Shifts with x2=-3, XLEN=64:
  - srai x5,x2,1 (0x40115293) -> x5=0xFFFFFFFFFFFFFFFE.
  - srli x6,x2,60 (0x03C15313) -> x6=0xF.
  - slli x7,x1,63 (0x03F09393) -> x7=0x8000000000000000.
- addi x0,x0,7 (0x00700013) -> dbg x0=0, retired increments. Then word 0xFFFFFFFF -> halted=1, illegal=1, retired unchanged.
- Assert rst in the EXEC cycle of add x3 -> x3 stays 0. busy=0, pc=START_PC, retired=0 next cycle.
- start pulses while busy -> no effect. start while HALTED -> re-runs from START_PC, retired restarts from 0.
- IMEM_AW=2, memory filled with addi x1,x1,1 -> imem_addr sequence 0,1,2,3,0. x1 increments every 2 cycles.
